// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: two one-entry writeback buffers, age-aware round-robin,
// one registered decoder-enable pulse per granted write. Optional: RF_WR_XZR_SUPPRESS_EN.
module regfile_write_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_data_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [DATA_WIDTH-1:0] req1_data_i,
  output logic [ADDR_WIDTH-1:0] dec_in_o,
  output logic                  dec_enable_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [1:0]            grant_o
);

  logic                  full0_q, full1_q;
  logic [ADDR_WIDTH-1:0] addr0_q, addr1_q;
  logic [DATA_WIDTH-1:0] data0_q, data1_q;
  logic                  age_q;  // 1: buffer 0 was loaded strictly before buffer 1
  logic                  rr_q;   // 1: requester 1 favoured on next different-address contention

  logic gnt0, gnt1, contend_diff;
  logic hs0, hs1, ld0, ld1;

  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    contend_diff = 1'b0;
    if (full0_q && full1_q) begin
      if (addr0_q == addr1_q) begin
        gnt0 = age_q;
        gnt1 = !age_q;
      end else begin
        contend_diff = 1'b1;
        gnt0         = !rr_q;
        gnt1         = rr_q;
      end
    end else begin
      gnt0 = full0_q;
      gnt1 = full1_q;
    end
  end

  assign req0_ready_o = !full0_q || gnt0;
  assign req1_ready_o = !full1_q || gnt1;
  assign hs0          = req0_valid_i && req0_ready_o;
  assign hs1          = req1_valid_i && req1_ready_o;

`ifdef RF_WR_XZR_SUPPRESS_EN
  // Writes to the zero register are consumed without ever occupying a buffer.
  assign ld0 = hs0 && !(&req0_addr_i);
  assign ld1 = hs1 && !(&req1_addr_i);
`else
  assign ld0 = hs0;
  assign ld1 = hs1;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full0_q      <= 1'b0;
      full1_q      <= 1'b0;
      addr0_q      <= '0;
      addr1_q      <= '0;
      data0_q      <= '0;
      data1_q      <= '0;
      age_q        <= 1'b0;
      rr_q         <= 1'b0;
      dec_enable_o <= 1'b0;
      dec_in_o     <= '0;
      wr_data_o    <= '0;
      grant_o      <= '0;
    end else begin
      if (gnt0) full0_q <= 1'b0;
      if (gnt1) full1_q <= 1'b0;
      if (ld0) begin
        full0_q <= 1'b1;
        addr0_q <= req0_addr_i;
        data0_q <= req0_data_i;
      end
      if (ld1) begin
        full1_q <= 1'b1;
        addr1_q <= req1_addr_i;
        data1_q <= req1_data_i;
      end
      // A fresh load is always the younger entry; simultaneous loads leave requester 1 older.
      if (ld0 || ld1) age_q <= ld1 && !ld0;
      if (contend_diff) rr_q <= !rr_q;

      dec_enable_o <= gnt0 || gnt1;
      grant_o      <= {gnt1, gnt0};
      if (gnt0) begin
        dec_in_o  <= addr0_q;
        wr_data_o <= data0_q;
      end else if (gnt1) begin
        dec_in_o  <= addr1_q;
        wr_data_o <= data1_q;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: timestamp-based reference model compared
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_write_arbiter;
  localparam int AW = 5;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          req0_valid_i, req1_valid_i;
  logic          req0_ready_o, req1_ready_o;
  logic [AW-1:0] req0_addr_i, req1_addr_i;
  logic [DW-1:0] req0_data_i, req1_data_i;
  logic [AW-1:0] dec_in_o;
  logic          dec_enable_o;
  logic [DW-1:0] wr_data_o;
  logic [1:0]    grant_o;

  regfile_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
    .dec_in_o(dec_in_o), .dec_enable_o(dec_enable_o),
    .wr_data_o(wr_data_o), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each buffer is an entry stamped with the cycle it was loaded.
  bit            m_v[2];
  logic [AW-1:0] m_a[2];
  logic [DW-1:0] m_d[2];
  int            m_t[2];
  bit            m_favor1;
  bit            m_live = 0;
  int            cyc = 0;
  logic          e_en;
  logic [1:0]    e_g;
  logic [AW-1:0] e_in;
  logic [DW-1:0] e_data;

  function automatic logic [1:0] mpick();
    if (m_v[0] && m_v[1]) begin
      if (m_a[0] == m_a[1]) return (m_t[0] < m_t[1]) ? 2'b01 : 2'b10;
      return m_favor1 ? 2'b10 : 2'b01;
    end
    if (m_v[0]) return 2'b01;
    if (m_v[1]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit keeps(input logic [AW-1:0] a);
`ifdef RF_WR_XZR_SUPPRESS_EN
    return a != {AW{1'b1}};
`else
    return (a == a);
`endif
  endfunction

  initial begin : model
    logic [1:0] g;
    bit h0, h1;
    forever begin
      @(posedge clk);
      if (reset_i) begin
        m_v[0] = 0; m_v[1] = 0; m_favor1 = 0;
        e_en = 0; e_g = 0; e_in = 0; e_data = 0;
        m_live = 1;
      end else begin
        g  = mpick();
        h0 = req0_valid_i && (!m_v[0] || g[0]);
        h1 = req1_valid_i && (!m_v[1] || g[1]);
        e_en = (g != 2'b00);
        e_g  = g;
        if (g[0]) begin e_in = m_a[0]; e_data = m_d[0]; end
        else if (g[1]) begin e_in = m_a[1]; e_data = m_d[1]; end
        if (m_v[0] && m_v[1] && m_a[0] != m_a[1]) m_favor1 = !m_favor1;
        if (g[0]) m_v[0] = 0;
        if (g[1]) m_v[1] = 0;
        if (h0 && keeps(req0_addr_i)) begin
          m_v[0] = 1; m_a[0] = req0_addr_i; m_d[0] = req0_data_i; m_t[0] = cyc;
        end
        if (h1 && keeps(req1_addr_i)) begin
          m_v[1] = 1; m_a[1] = req1_addr_i; m_d[1] = req1_data_i; m_t[1] = cyc;
        end
      end
      cyc++;
    end
  end

  initial begin : compare
    logic [1:0] g;
    forever begin
      @(negedge clk);
      if (m_live) begin
        g = mpick();
        chk("dec_enable", dec_enable_o, e_en);
        chk("grant", grant_o, e_g);
        chk("dec_in", dec_in_o, e_in);
        chk("wr_data", wr_data_o, e_data);
        chk("req0_ready", req0_ready_o, !m_v[0] || g[0]);
        chk("req1_ready", req1_ready_o, !m_v[1] || g[1]);
      end
    end
  end

  // Drive one cycle of inputs, then return just after the rising edge that samples them.
  task automatic step(input bit rst, input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    @(negedge clk);
    reset_i = rst;
    req0_valid_i = v0; req0_addr_i = a0; req0_data_i = d0;
    req1_valid_i = v1; req1_addr_i = a1; req1_data_i = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : stim
    int pulses, drops;
    bit rst, v0, v1;
    logic [AW-1:0] a0, a1;
    reset_i = 1; req0_valid_i = 0; req1_valid_i = 0;
    req0_addr_i = 0; req1_addr_i = 0; req0_data_i = 0; req1_data_i = 0;

    // Reset held two cycles with both requesters pushing.
    step(1, 1, 3, 64'h1, 1, 4, 64'h2);
    step(1, 1, 3, 64'h1, 1, 4, 64'h2);
    idle();
    chk("rst_en", dec_enable_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_dec_in", dec_in_o, 0);
    chk("rst_data", wr_data_o, 0);
    chk("rst_rdy0", req0_ready_o, 1);
    chk("rst_rdy1", req1_ready_o, 1);
    idle();
    chk("rst_en2", dec_enable_o, 0);

    // Single write.
    step(0, 1, 5, 64'hAA, 0, 0, 0);
    idle();
    chk("single_en", dec_enable_o, 1);
    chk("single_in", dec_in_o, 5);
    chk("single_data", wr_data_o, 64'hAA);
    chk("single_grant", grant_o, 2'b01);
    idle();
    chk("single_pulse_end", dec_enable_o, 0);
    chk("single_hold_in", dec_in_o, 5);

    // Simultaneous writes, requester 0 favoured.
    step(0, 1, 3, 64'h33, 1, 7, 64'h77);
    chk("simul_rdy0", req0_ready_o, 1);
    chk("simul_rdy1", req1_ready_o, 0);
    idle();
    chk("simul_first_in", dec_in_o, 3);
    chk("simul_first_grant", grant_o, 2'b01);
    idle();
    chk("simul_second_in", dec_in_o, 7);
    chk("simul_second_grant", grant_o, 2'b10);
    chk("simul_second_data", wr_data_o, 64'h77);

    // Same address: requester 1 loaded one cycle earlier must issue first.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 2, 64'h22, 1, 9, 64'h91);
    step(0, 1, 9, 64'h90, 0, 0, 0);
    chk("age_busy_in", dec_in_o, 2);
    idle();
    chk("age_first_data", wr_data_o, 64'h91);
    chk("age_first_grant", grant_o, 2'b10);
    idle();
    chk("age_second_data", wr_data_o, 64'h90);
    chk("age_second_grant", grant_o, 2'b01);

    // Same address loaded on the same edge: requester 1 wins despite round-robin favouring 0.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 9, 64'hA0, 1, 9, 64'hA1);
    step(0, 0, 0, 0, 1, 9, 64'hB1);
    chk("tie_first_grant", grant_o, 2'b10);
    chk("tie_first_data", wr_data_o, 64'hA1);
    idle();
    chk("tie_second_data", wr_data_o, 64'hA0);
    idle();
    chk("tie_third_data", wr_data_o, 64'hB1);

    // Back-to-back streaming on requester 0.
    pulses = 0; drops = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) step(0, 1, AW'(i + 1), 64'(i + 16), 0, 0, 0);
      else idle();
      if (i > 0 && dec_enable_o) pulses++;
      if (i < 8 && !req0_ready_o) drops++;
    end
    chk("stream_pulses", pulses, 8);
    chk("stream_ready_drops", drops, 0);

    // Zero register.
    step(0, 1, 31, 64'h31, 0, 0, 0);
    idle();
`ifdef RF_WR_XZR_SUPPRESS_EN
    chk("xzr_en", dec_enable_o, 0);
`else
    chk("xzr_en", dec_enable_o, 1);
    chk("xzr_in", dec_in_o, 31);
`endif

    // Randomized traffic with a small address pool to provoke same-address collisions.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 250) == 0;
      v0  = ($urandom % 4) != 0;
      v1  = ($urandom % 3) != 0;
      a0  = (($urandom % 8) == 0) ? AW'(31) : AW'($urandom % 4);
      a1  = (($urandom % 8) == 0) ? AW'(31) : AW'($urandom % 4);
      step(rst, v0, a0, {$urandom, $urandom}, v1, a1, {$urandom, $urandom});
    end
    repeat (4) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequencing controller for the register file write port. Two writeback sources share the single 5x32 enabled write-address decoder:

- **Requester 0:** execute/ALU writeback.
- **Requester 1:** memory/load writeback.

Each source has a one-entry holding buffer. The block arbitrates between them with age-aware round-robin. It drives exactly one registered decoder enable pulse per granted write, so the write port can retire one write every cycle.

## Interface
Parameters:
- ADDR_WIDTH, 5, register address width; the decoder fans out 2**ADDR_WIDTH = 32 enables.
- DATA_WIDTH, 64, writeback data width.

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge.
- reset_i  input  1  reset, synchronous and active-high.
- req0_valid_i  input  1  requester 0 has a write.
- req0_ready_o  output  1  requester 0 buffer can accept this cycle.
- req0_addr_i  input  ADDR_WIDTH  requester 0 destination register.
- req0_data_i  input  DATA_WIDTH  requester 0 write data.
- req1_valid_i / req1_ready_o / req1_addr_i / req1_data_i: same as requester 0, for requester 1.
- dec_in_o  output  ADDR_WIDTH  to decoder in_i.
- dec_enable_o  output  1  to decoder enable_i; one-cycle pulse per write.
- wr_data_o  output  DATA_WIDTH  data accompanying dec_enable_o.
- grant_o  output  2  one-hot; identifies the requester whose write is on the outputs; 0 when idle.

## Operation

**Buffers**
- Each requester has a buffer holding full_q, addr_q and data_q.
- Accept when valid_i && ready_o on the rising edge.

**Ready**
- ready_o = !full_q || grant_now for that requester.
- grant_now is computed from registered state only, so there is no combinational valid-to-ready path.

**Grant selection** (each cycle, among full buffers):
- Only one full: grant it.
- Both full, same addr_q: grant the older buffer (age_q). If both were loaded on the same edge, grant requester 1, which is older in pipeline order.
- Both full, different addr_q: grant the requester not granted last (rr_q). rr_q then toggles.

**Output register**
- On grant: dec_enable_o <= 1, dec_in_o <= granted addr_q, wr_data_o <= granted data_q, grant_o <= one-hot.
- With no grant: dec_enable_o <= 0 and grant_o <= 0. dec_in_o and wr_data_o hold their previous values.

**Buffer update**
- The granted buffer clears on the same edge.
- If its requester also handshakes that edge, the buffer reloads with the new entry. Such an entry is younger than the other buffer's entry.
- age_q marks the buffer loaded strictly earlier. Equal load edges fall to the requester 1 rule above.

**Reset**
- While reset_i is high at an edge, all state clears: full_q = 0, age_q = 0, rr_q = 0 (requester 0 favoured next), dec_enable_o = 0, dec_in_o = 0, wr_data_o = 0, grant_o = 0.
- ready_o = 1 for both requesters after reset.
- A buffered entry pending at reset is dropped and never issued.
- A handshake presented in a reset cycle is ignored.

## Timing
- Latency: a handshake at edge N produces dec_enable_o high after edge N+1, if granted there. It stays high for exactly one cycle unless another grant follows back to back.
- Single requester streaming valid every cycle: one write per cycle, ready_o held at 1.
- Both requesters streaming: writes alternate 0/1/0/1. Each requester sees ready_o = 0 in the cycles it is not granted.
- Worst-case wait for a full buffer is 1 cycle; the other buffer can win at most once.

## Configuration
- RF_WR_XZR_SUPPRESS_EN defined:
  - A handshake whose address is all-ones (register 31, zero register) is accepted but never loaded into the buffer.
  - full_q stays 0 and no decoder enable is produced.
- Not defined: address 31 is treated like any other address and produces dec_enable_o with dec_in_o = 31.

## Test plan
- **Reset:** hold reset_i 2 cycles with both valids high -> all outputs 0, both ready_o = 1, no dec_enable_o for 2 cycles after release.
- **Single write:** req0 handshakes addr 5 / data 0xAA at edge N -> dec_enable_o = 1, dec_in_o = 5, wr_data_o = 0xAA, grant_o = 01 after edge N+1 for one cycle.
- **Simultaneous writes:** req0 addr 3 and req1 addr 7 handshake at the same edge, rr_q = 0 -> addr 3 issued first, then addr 7; req1_ready_o = 0 for one cycle.
- **Same-address ordering:** req1 addr 9 loaded one cycle before req0 addr 9 while the port is busy -> req1's data issued before req0's.
- **Back-to-back streaming:** req0 valid for 8 consecutive cycles -> 8 consecutive dec_enable_o pulses, ready_o never 0.
- **Zero register:** req0 handshakes addr 31 -> with RF_WR_XZR_SUPPRESS_EN, no dec_enable_o; without it, dec_enable_o pulses with dec_in_o = 31.
